// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a clock-enable pixel divider.
// Optional one-pixel prefetch outputs are enabled by defining VGA_TIMING_LOOKAHEAD_EN.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_ce,
  output logic          h_sync,
  output logic          v_sync,
  output logic          active,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [31:0]   frame_count
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y
`endif
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  localparam logic [DW-1:0] D_LAST    = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_B   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_E   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_B   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_E   = VW'(V_SYNC + V_BP + V_ACTIVE);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          act;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } dec_t;

  function automatic dec_t decode(input logic [HW-1:0] h, input logic [VW-1:0] v);
    dec_t d;
    logic h_in;
    logic v_in;
    h_in  = (h >= H_ACT_B) && (h < H_ACT_E);
    v_in  = (v >= V_ACT_B) && (v < V_ACT_E);
    d.hs  = (h < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    d.vs  = (v < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    d.act = h_in && v_in;
    d.x   = d.act ? CW'(h - H_ACT_B) : '0;
    d.y   = d.act ? CW'(v - V_ACT_B) : '0;
    return d;
  endfunction

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  dec_t          dec_q, dec_d;
  logic          pix_ce_q, line_start_q, frame_start_q;
  logic [31:0]   frame_count_q, frame_count_d;
  logic          tick, new_line, new_frame;

`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [HW-1:0] h_nn;
  logic [VW-1:0] v_nn;
  dec_t          fdec_q, fdec_d;
`endif

  always_comb begin
    tick   = (dcnt_q == D_LAST);
    dcnt_d = tick ? '0 : dcnt_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    new_line      = tick && (h_d == '0);
    new_frame     = new_line && (v_d == '0);
    dec_d         = tick ? decode(h_d, v_d) : dec_q;
    frame_count_d = new_frame ? frame_count_q + 32'd1 : frame_count_q;
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  // Decode the position one pixel beyond the one being entered, so a
  // one-cycle-latency RAM read issued now lands with the next pix_ce.
  always_comb begin
    h_nn = h_d;
    v_nn = v_d;
    if (h_d == H_LAST) begin
      h_nn = '0;
      v_nn = (v_d == V_LAST) ? '0 : v_d + 1'b1;
    end else begin
      h_nn = h_d + 1'b1;
    end
    fdec_d = tick ? decode(h_nn, v_nn) : fdec_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      dcnt_q        <= '0;
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      dec_q         <= '{hs: ~SYNC_POL, vs: ~SYNC_POL, act: 1'b0, x: '0, y: '0};
      pix_ce_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      dcnt_q        <= dcnt_d;
      h_q           <= h_d;
      v_q           <= v_d;
      dec_q         <= dec_d;
      pix_ce_q      <= tick;
      line_start_q  <= new_line;
      frame_start_q <= new_frame;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fdec_q <= '0;
    end else begin
      fdec_q <= fdec_d;
    end
  end

  assign fetch_valid = fdec_q.act;
  assign fetch_x     = fdec_q.x;
  assign fetch_y     = fdec_q.y;
`endif

  assign pix_ce      = pix_ce_q;
  assign h_sync      = dec_q.hs;
  assign v_sync      = dec_q.vs;
  assign active      = dec_q.act;
  assign pix_x       = dec_q.x;
  assign pix_y       = dec_q.y;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small raster configurations checked each cycle
// against an arithmetic position model, with random mid-frame resets.
module tb_vga_timing_gen;

  typedef struct {
    int unsigned cd, hs, hbp, ha, hfp, vs, vbp, va, vfp;
    bit pol;
  } cfg_t;

  typedef struct {
    bit ce, hs, vs, act, ls, fs, fv;
    int unsigned x, y, fc, fx, fy;
  } exp_t;

  cfg_t cA = '{3, 3, 2, 5, 2, 2, 2, 4, 1, 1'b0};
  cfg_t cB = '{1, 2, 1, 4, 1, 1, 1, 3, 1, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;

  logic        a_ce, a_hs, a_vs, a_act, a_ls, a_fs;
  logic [15:0] a_x, a_y;
  logic [31:0] a_fc;
  logic        b_ce, b_hs, b_vs, b_act, b_ls, b_fs;
  logic [15:0] b_x, b_y;
  logic [31:0] b_fc;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic        a_fv, b_fv;
  logic [15:0] a_fx, a_fy, b_fx, b_fy;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(3), .H_SYNC(3), .H_BP(2), .H_ACTIVE(5), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1), .SYNC_POL(1'b0), .CW(16)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_ce(a_ce), .h_sync(a_hs), .v_sync(a_vs),
    .active(a_act), .pix_x(a_x), .pix_y(a_y), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .fetch_valid(a_fv), .fetch_x(a_fx), .fetch_y(a_fy)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .SYNC_POL(1'b1), .CW(16)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_ce(b_ce), .h_sync(b_hs), .v_sync(b_vs),
    .active(b_act), .pix_x(b_x), .pix_y(b_y), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .fetch_valid(b_fv), .fetch_x(b_fx), .fetch_y(b_fy)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_active(input cfg_t c, input int unsigned h, input int unsigned v);
    return (h >= c.hs + c.hbp) && (h < c.hs + c.hbp + c.ha) &&
           (v >= c.vs + c.vbp) && (v < c.vs + c.vbp + c.va);
  endfunction

  // t = clock edges with rst high since the last reset edge; pixel k is entered at edge k*cd.
  function automatic exp_t model(input cfg_t c, input int unsigned t);
    exp_t e;
    int unsigned k, ht, vt, p, h, v, hn, vn;
    e = '{default: 0};
    e.hs = ~c.pol;
    e.vs = ~c.pol;
    k = t / c.cd;
    if (k == 0) return e;
    ht = c.hs + c.hbp + c.ha + c.hfp;
    vt = c.vs + c.vbp + c.va + c.vfp;
    p  = k - 1;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.ce  = (t % c.cd) == 0;
    e.hs  = (h < c.hs) ? c.pol : ~c.pol;
    e.vs  = (v < c.vs) ? c.pol : ~c.pol;
    e.act = in_active(c, h, v);
    e.x   = e.act ? h - (c.hs + c.hbp) : 0;
    e.y   = e.act ? v - (c.vs + c.vbp) : 0;
    e.ls  = e.ce && (h == 0);
    e.fs  = e.ls && (v == 0);
    e.fc  = p / (ht * vt) + 1;
    hn = (p + 1) % ht;
    vn = ((p + 1) / ht) % vt;
    e.fv = in_active(c, hn, vn);
    e.fx = e.fv ? hn - (c.hs + c.hbp) : 0;
    e.fy = e.fv ? vn - (c.vs + c.vbp) : 0;
    return e;
  endfunction

  int unsigned tA = 0;
  int unsigned tB = 0;

  initial begin
    exp_t eA, eB;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        tA = 0;
        tB = 0;
      end else begin
        tA++;
        tB++;
      end
      eA = model(cA, tA);
      eB = model(cB, tB);
      check("A.pix_ce", a_ce, eA.ce);
      check("A.h_sync", a_hs, eA.hs);
      check("A.v_sync", a_vs, eA.vs);
      check("A.active", a_act, eA.act);
      check("A.pix_x", a_x, eA.x);
      check("A.pix_y", a_y, eA.y);
      check("A.line_start", a_ls, eA.ls);
      check("A.frame_start", a_fs, eA.fs);
      check("A.frame_count", a_fc, eA.fc);
      check("B.pix_ce", b_ce, eB.ce);
      check("B.h_sync", b_hs, eB.hs);
      check("B.v_sync", b_vs, eB.vs);
      check("B.active", b_act, eB.act);
      check("B.pix_x", b_x, eB.x);
      check("B.pix_y", b_y, eB.y);
      check("B.line_start", b_ls, eB.ls);
      check("B.frame_start", b_fs, eB.fs);
      check("B.frame_count", b_fc, eB.fc);
`ifdef VGA_TIMING_LOOKAHEAD_EN
      check("A.fetch_valid", a_fv, eA.fv);
      check("A.fetch_x", a_fx, eA.fx);
      check("A.fetch_y", a_fy, eA.fy);
      check("B.fetch_valid", b_fv, eB.fv);
      check("B.fetch_x", b_fx, eB.fx);
      check("B.fetch_y", b_fy, eB.fy);
`endif
    end
  end

  initial begin
    int a_fs1, a_fs2, b_fs1, b_fs2, b_ls2, nb;
    logic [15:0] xs [4];
    a_fs1 = 0; a_fs2 = 0; b_fs1 = 0; b_fs2 = 0; b_ls2 = 0; nb = 0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    check("reset A.h_sync", a_hs, 1);
    check("reset B.h_sync", b_hs, 0);
    check("reset A.frame_count", a_fc, 0);
    check("reset A.pix_ce", a_ce, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 700; n++) begin
      @(posedge clk);
      #1;
      if (a_fs) begin
        if (a_fs1 == 0) a_fs1 = n;
        else if (a_fs2 == 0) a_fs2 = n;
      end
      if (b_fs) begin
        if (b_fs1 == 0) b_fs1 = n;
        else if (b_fs2 == 0) b_fs2 = n;
      end
      if (b_ls && n > 1 && b_ls2 == 0) b_ls2 = n;
      if (b_ce && b_act && nb < 4) begin
        xs[nb] = b_x;
        nb++;
      end
    end
    check("A first frame_start cycle", a_fs1, 3);
    check("A frame period", a_fs2 - a_fs1, 324);
    check("B first frame_start cycle", b_fs1, 1);
    check("B frame period", b_fs2 - b_fs1, 48);
    check("B line period", b_ls2 - 1, 8);
    check("B pix_x[0]", xs[0], 0);
    check("B pix_x[1]", xs[1], 1);
    check("B pix_x[2]", xs[2], 2);
    check("B pix_x[3]", xs[3], 3);
    check("A frame_count after 700", a_fc, 3);

    repeat (14) begin
      repeat ($urandom_range(20, 450)) @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b1;
    end
    repeat (400) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
